// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register and its serialiser.
package shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_ROR  = 3'd5,
        MODE_SCLR = 3'd6,
        MODE_RSVD = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/univ_shift_reg_bit_cnt.sv
// Saturating bit counter, falling-edge clocked, with async active-low clear,
// sync clear and a terminal-count flag at N-1.
module bit_cnt #(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          en,
    input  logic          sclr,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    assign tc = (cnt == CW'(N - 1));

    // sclr wins over en; the count never advances past N-1
    always_ff @(negedge clk or negedge clr) begin
        if (!clr)
            cnt <= '0;
        else if (sclr)
            cnt <= '0;
        else if (en && !tc)
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal N-bit register: six per-cycle modes plus a self-timed LSB-first
// serialiser (IDLE -> XFER -> FIN). All state changes on the falling edge.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         EN,
    input  logic [2:0]   MODE,
    input  logic [N-1:0] D,
    input  logic         SIL,
    input  logic         SIR,
    input  logic         START,
    output logic [N-1:0] Q,
    output logic         SOL,
    output logic         SOR,
    output logic         BUSY,
    output logic         DONE
);

    localparam int CW = $clog2(N);

    state_e          state, state_nx;
    logic [N-1:0]    q_nx;
    logic            cnt_sclr, cnt_inc, cnt_tc;
    logic [CW-1:0]   cnt;

    bit_cnt #(.N(N), .CW(CW)) u_cnt (
        .clk  (CLK),
        .clr  (CLR),
        .en   (cnt_inc),
        .sclr (cnt_sclr),
        .cnt  (cnt),
        .tc   (cnt_tc)
    );

    always_ff @(negedge CLK or negedge CLR) begin
        if (!CLR) begin
            state <= IDLE;
            Q     <= '0;
        end else if (EN) begin
            state <= state_nx;
            Q     <= q_nx;
        end
    end

    always_comb begin
        state_nx = state;
        q_nx     = Q;
        cnt_sclr = 1'b0;
        cnt_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    q_nx     = D;
                    cnt_sclr = EN;
                    state_nx = XFER;
                end else begin
                    case (mode_e'(MODE))
                        MODE_LOAD: q_nx = D;
                        MODE_SHL:  q_nx = {Q[N-2:0], SIR};
                        MODE_SHR:  q_nx = {SIL, Q[N-1:1]};
                        MODE_ROL:  q_nx = {Q[N-2:0], Q[N-1]};
                        MODE_ROR:  q_nx = {Q[0], Q[N-1:1]};
                        MODE_SCLR: q_nx = '0;
                        default:   q_nx = Q;
                    endcase
                end
            end
            XFER: begin
                q_nx = {SIL, Q[N-1:1]};
                // counter returns to 0 on the last bit so it idles at zero
                if (cnt_tc) begin
                    cnt_sclr = EN;
                    state_nx = FIN;
                end else begin
                    cnt_inc = EN;
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign SOL  = Q[N-1];
    assign SOR  = Q[0];
    assign BUSY = (state == XFER);
    assign DONE = (state == FIN);

    a_cnt_idle: assert property (@(posedge CLK) disable iff (!CLR)
        (state != XFER) |-> (cnt == '0));

endmodule
